// File: rtl/spi_register_bridge_pkg.sv
// Shared constants and state encoding for the SPI-to-register-file bridge.
package spi_register_bridge_pkg;

  localparam int SPI_RW_BIT   = 7;
  localparam int SPI_CMD_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/spi_register_bridge_if.sv
// Register-file bus between the SPI bridge (master) and the register block (slave).
interface spi_register_bridge_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] reg_address;
  logic [DATA_WIDTH-1:0] reg_wdata;
  logic                  reg_wvalid;
  logic                  reg_read;
  logic [DATA_WIDTH-1:0] reg_rdata;

  modport master (
    output reg_address,
    output reg_wdata,
    output reg_wvalid,
    output reg_read,
    input  reg_rdata
  );

  modport slave (
    input  reg_address,
    input  reg_wdata,
    input  reg_wvalid,
    input  reg_read,
    output reg_rdata
  );

endinterface

// File: rtl/spi_register_bridge_sync.sv
// Synchronises the SPI pins into the clk domain and detects sclk / cs_n edges.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise,
  output logic mosi_s
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cs_d;

  // Reset to idle bus levels so leaving reset never fabricates an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
  assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_d;
  assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_d;
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave: 8-bit command plus DATA_WIDTH-bit data frame mapped onto the register-file bus.
module spi_register_bridge
  import spi_register_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         spi_sclk,
  input  logic                         spi_cs_n,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic                         spi_miso_oe,
  output logic                         busy,
  output logic                         frame_abort,
  spi_register_bridge_if.master        reg_bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(SPI_CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_WIDTH - 1);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic                  write_frame;
  logic                  first_fall;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .sclk      (spi_sclk),
    .cs_n      (spi_cs_n),
    .mosi      (spi_mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise),
    .mosi_s    (mosi_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      bit_cnt             <= '0;
      rx_shift            <= '0;
      tx_shift            <= '0;
      write_frame         <= 1'b0;
      first_fall          <= 1'b0;
      spi_miso            <= 1'b0;
      spi_miso_oe         <= 1'b0;
      busy                <= 1'b0;
      frame_abort         <= 1'b0;
      reg_bus.reg_address <= '0;
      reg_bus.reg_wdata   <= '0;
      reg_bus.reg_wvalid  <= 1'b0;
      reg_bus.reg_read    <= 1'b0;
    end else begin
      reg_bus.reg_wvalid <= 1'b0;
      reg_bus.reg_read   <= 1'b0;
      frame_abort        <= 1'b0;
      // cs_n release outranks everything, including a coincident final data bit.
      if (cs_rise && state != IDLE) begin
        state       <= IDLE;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
        frame_abort <= (state == CMD) || (state == DATA);
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state       <= CMD;
              bit_cnt     <= '0;
              spi_miso    <= 1'b0;
              spi_miso_oe <= 1'b1;
              busy        <= 1'b1;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
              if (bit_cnt == LAST_CMD) begin
                reg_bus.reg_address <= {rx_shift[ADDR_WIDTH-2:0], mosi_s};
                write_frame         <= rx_shift[SPI_RW_BIT-1];
                first_fall          <= 1'b1;
                bit_cnt             <= '0;
                state               <= DATA;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
              if (bit_cnt == LAST_DATA) begin
                state    <= DONE;
                spi_miso <= 1'b0;
                if (write_frame) begin
                  reg_bus.reg_wdata  <= {rx_shift, mosi_s};
                  reg_bus.reg_wvalid <= 1'b1;
                end else begin
                  reg_bus.reg_read <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end else if (sclk_fall && !write_frame) begin
              // First fall takes reg_rdata live; it has settled by then at the 8x clock ratio.
              if (first_fall) begin
                spi_miso   <= reg_bus.reg_rdata[DATA_WIDTH-1];
                tx_shift   <= {reg_bus.reg_rdata[DATA_WIDTH-2:0], 1'b0};
                first_fall <= 1'b0;
              end else begin
                spi_miso <= tx_shift[DATA_WIDTH-1];
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          DONE: begin
            spi_miso <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_register_bridge.sv
// Directed bench: drives SPI mode-0 frames at sclk = clk/8 against a registered register-file model.
module tb_spi_register_bridge;

  logic clk = 1'b0;
  logic rst;
  logic sclk, cs_n, mosi;
  logic miso, miso_oe, busy, frame_abort;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int wvalid_cnt = 0;
  int read_cnt   = 0;
  int abort_cnt  = 0;
  logic [5:0]  wv_addr = '0;
  logic [31:0] wv_data = '0;

  spi_register_bridge_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  spi_register_bridge #(
    .ADDR_WIDTH  (6),
    .DATA_WIDTH  (32),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_sclk    (sclk),
    .spi_cs_n    (cs_n),
    .spi_mosi    (mosi),
    .spi_miso    (miso),
    .spi_miso_oe (miso_oe),
    .busy        (busy),
    .frame_abort (frame_abort),
    .reg_bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_word(input logic [5:0] addr);
    case (addr)
      6'h00:   return 32'h4101_0203;
      6'h01:   return 32'hC3A5_5A3C;
      default: return 32'hDEAD_0000 | {26'h0, addr};
    endcase
  endfunction

  // Register file returns data one clk after the address changes.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.reg_rdata <= '0;
    else     bus.reg_rdata <= model_word(bus.reg_address);
  end

  always @(negedge clk) begin
    if (bus.reg_wvalid) begin
      wvalid_cnt++;
      wv_addr = bus.reg_address;
      wv_data = bus.reg_wdata;
    end
    if (bus.reg_read) read_cnt++;
    if (frame_abort)  abort_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Clocks 8 + data_bits sclk periods; bits beyond the 32-bit data phase drive mosi high.
  task automatic apply_stimulus(input logic [7:0] cmd, input logic [31:0] data, input int data_bits,
                                input bit raise_cs, output logic [31:0] miso_word, output int late_ones);
    miso_word = '0;
    late_ones = 0;
    cs_n = 1'b0;
    for (int i = 0; i < 8 + data_bits; i++) begin
      if (i < 8)       mosi = cmd[7-i];
      else if (i < 40) mosi = data[39-i];
      else             mosi = 1'b1;
      repeat (4) @(negedge clk);
      if (i >= 8 && i < 40) miso_word = {miso_word[30:0], miso};
      if (i >= 40 && miso) late_ones++;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    if (raise_cs) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_miso"},    32'(miso), 32'h0);
    check_output({tag, "_oe"},      32'(miso_oe), 32'h0);
    check_output({tag, "_busy"},    32'(busy), 32'h0);
    check_output({tag, "_abort"},   32'(frame_abort), 32'h0);
    check_output({tag, "_addr"},    32'(bus.reg_address), 32'h0);
    check_output({tag, "_wdata"},   bus.reg_wdata, 32'h0);
    check_output({tag, "_wvalid"},  32'(bus.reg_wvalid), 32'h0);
    check_output({tag, "_read"},    32'(bus.reg_read), 32'h0);
  endtask

  initial begin
    logic [31:0] miso_word;
    int late_ones;
    int base_w, base_r, base_a;

    rst  = 1'b1;
    sclk = 1'b0;
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write frame: cmd 0x90 -> write to 0x10
    base_w = wvalid_cnt; base_r = read_cnt; base_a = abort_cnt;
    apply_stimulus(8'h90, 32'h80FF_0000, 32, 1'b1, miso_word, late_ones);
    check_output("wr_wvalid_cnt", 32'(wvalid_cnt - base_w), 32'd1);
    check_output("wr_read_cnt",   32'(read_cnt - base_r), 32'd0);
    check_output("wr_abort_cnt",  32'(abort_cnt - base_a), 32'd0);
    check_output("wr_strobe_addr", 32'(wv_addr), 32'h10);
    check_output("wr_strobe_data", wv_data, 32'h80FF_0000);
    check_output("wr_addr",  32'(bus.reg_address), 32'h10);
    check_output("wr_wdata", bus.reg_wdata, 32'h80FF_0000);
    check_output("wr_oe_after",   32'(miso_oe), 32'h0);
    check_output("wr_busy_after", 32'(busy), 32'h0);

    // Read frame: cmd 0x00 -> read from 0x00
    base_w = wvalid_cnt; base_r = read_cnt;
    apply_stimulus(8'h00, 32'h0000_0000, 32, 1'b1, miso_word, late_ones);
    check_output("rd_miso_word",  miso_word, 32'h4101_0203);
    check_output("rd_read_cnt",   32'(read_cnt - base_r), 32'd1);
    check_output("rd_wvalid_cnt", 32'(wvalid_cnt - base_w), 32'd0);
    check_output("rd_wdata_kept", bus.reg_wdata, 32'h80FF_0000);

    // Abort: write cmd 0xA1, cs_n released after 20 data bits
    base_w = wvalid_cnt; base_r = read_cnt; base_a = abort_cnt;
    apply_stimulus(8'hA1, 32'hFFFF_FFFF, 20, 1'b0, miso_word, late_ones);
    check_output("ab_busy_mid", 32'(busy), 32'h1);
    check_output("ab_oe_mid",   32'(miso_oe), 32'h1);
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    check_output("ab_abort_cnt",  32'(abort_cnt - base_a), 32'd1);
    check_output("ab_wvalid_cnt", 32'(wvalid_cnt - base_w), 32'd0);
    check_output("ab_read_cnt",   32'(read_cnt - base_r), 32'd0);
    check_output("ab_wdata_kept", bus.reg_wdata, 32'h80FF_0000);
    check_output("ab_addr",       32'(bus.reg_address), 32'h21);

    // Back-to-back: read 0x01, one sclk period of cs_n high, write 0x02
    base_w = wvalid_cnt; base_r = read_cnt;
    apply_stimulus(8'h01, 32'h0000_0000, 32, 1'b1, miso_word, late_ones);
    check_output("b2b_rd_word", miso_word, 32'hC3A5_5A3C);
    check_output("b2b_oe_gap",  32'(miso_oe), 32'h0);
    repeat (2) @(negedge clk);
    apply_stimulus(8'h82, 32'h1234_5678, 32, 1'b1, miso_word, late_ones);
    check_output("b2b_read_cnt",   32'(read_cnt - base_r), 32'd1);
    check_output("b2b_wvalid_cnt", 32'(wvalid_cnt - base_w), 32'd1);
    check_output("b2b_wr_addr",    32'(wv_addr), 32'h02);
    check_output("b2b_wr_data",    wv_data, 32'h1234_5678);

    // Overclock: 48 sclk periods in one write frame
    base_w = wvalid_cnt; base_a = abort_cnt;
    apply_stimulus(8'h85, 32'hCAFE_F00D, 40, 1'b1, miso_word, late_ones);
    check_output("oc_wvalid_cnt", 32'(wvalid_cnt - base_w), 32'd1);
    check_output("oc_wr_addr",    32'(wv_addr), 32'h05);
    check_output("oc_wr_data",    wv_data, 32'hCAFE_F00D);
    check_output("oc_late_miso",  32'(late_ones), 32'd0);
    check_output("oc_abort_cnt",  32'(abort_cnt - base_a), 32'd0);

    // Reset at data bit 10 of a write, then a fresh full write
    base_w = wvalid_cnt; base_r = read_cnt; base_a = abort_cnt;
    apply_stimulus(8'h83, 32'h0BAD_F00D, 10, 1'b0, miso_word, late_ones);
    rst = 1'b1;
    #1;
    check_reset_values("rst_mid");
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_output("rst_no_wvalid", 32'(wvalid_cnt - base_w), 32'd0);
    apply_stimulus(8'h84, 32'h5A5A_A5A5, 32, 1'b1, miso_word, late_ones);
    check_output("rst_wvalid_cnt", 32'(wvalid_cnt - base_w), 32'd1);
    check_output("rst_wr_addr",    32'(wv_addr), 32'h04);
    check_output("rst_wr_data",    wv_data, 32'h5A5A_A5A5);
    check_output("rst_read_cnt",   32'(read_cnt - base_r), 32'd0);
    check_output("rst_abort_cnt",  32'(abort_cnt - base_a), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_register_bridge.md
Name: spi_register_bridge

Overview:
- SPI slave that gives the host processor access to the FPGA register file.
- Deserialises a 5-byte frame: 1 command byte followed by 32 data bits.
- Drives the register file's address, write data, write strobe and read strobe.
- Serialises the register file's registered read data back onto MISO.
- Sits directly upstream of the register block; all logic runs in the clk domain with oversampled SPI inputs.

Parameters:
- ADDR_WIDTH, 6, register address width (command byte bits 5:0)
- DATA_WIDTH, 32, register data width; frame data phase length in bits
- SYNC_STAGES, 2, flip-flop synchroniser depth on spi_sclk, spi_cs_n and spi_mosi

Ports:
- clk  input  1  system clock; must be at least 8x the spi_sclk frequency
- rst  input  1  reset, asynchronous, active-high
- spi_sclk  input  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
- spi_cs_n  input  1  chip select, active low; frames one transaction
- spi_mosi  input  1  master-to-slave data, MSB first
- spi_miso  output  1  slave-to-master data, MSB first
- spi_miso_oe  output  1  MISO output enable; the pad tristates when 0
- reg_address  output  ADDR_WIDTH  register address; holds until the next command byte
- reg_wdata  output  DATA_WIDTH  write data to the register file
- reg_wvalid  output  1  single-cycle write strobe
- reg_read  output  1  single-cycle read-complete strobe; drives clear-on-read behaviour
- reg_rdata  input  DATA_WIDTH  registered read data; valid 1 clk after reg_address changes
- busy  output  1  high while spi_cs_n is synchronised low
- frame_abort  output  1  single-cycle pulse when a frame ends early

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, reg_address=0, reg_wdata=0, reg_wvalid=0, reg_read=0, busy=0, frame_abort=0. State=IDLE, bit counter=0, synchroniser flops=idle levels (sclk=0, cs_n=1).
- Synchronisation and edge detection:
  - Each SPI input passes through SYNC_STAGES flops.
  - A rise or fall is detected by comparing the last synchroniser stage with one extra delay flop.
  - All decisions are made on detected edges, never on raw pins.
- Frame format:
  - Command byte: bit7 = R/W (1 = write, 0 = read); bit6 reserved and ignored; bits5:0 = address.
  - Data phase: DATA_WIDTH bits, MSB first.
- State machine: IDLE -> CMD -> DATA -> DONE.
  - IDLE: cs_n falling edge -> CMD, bit counter cleared, busy=1, spi_miso_oe=1, spi_miso=0.
  - CMD: MOSI is sampled on each sclk rise. On the 8th rise, reg_address is loaded in the following clk, the R/W flag is latched, and the state moves to DATA.
  - DATA on a read: on the first sclk fall after entering DATA, bit 31 of reg_rdata is loaded into the shift register and driven on spi_miso. Each later fall shifts the next bit out.
  - DATA on a write: MOSI is shifted in on each sclk rise.
  - DATA exit: on the 32nd data-phase rise the state moves to DONE.
    - Write frame: reg_wdata takes the assembled word, and reg_wvalid pulses 1 clk in the same cycle.
    - Read frame: reg_read pulses 1 clk.
  - DONE: further sclk edges are ignored; spi_miso is held at 0.
  - Any state other than IDLE: cs_n rising edge -> IDLE, spi_miso_oe=0, busy=0.
- Abort:
  - A cs_n rise in CMD, or in DATA before 32 data bits -> frame_abort pulses 1 clk.
  - No reg_wvalid and no reg_read are issued; reg_wdata is unchanged.
  - reg_address keeps its value if it was already loaded.
- Read timing:
  - The 8th rise is detected in cycle N; reg_address is valid at N+1; reg_rdata is valid at N+2.
  - At the 8x clock ratio, the first fall is detected no earlier than N+3, so the load uses reg_rdata live.
- Simultaneous events:
  - cs_n rise coinciding with the 32nd rise: cs_n wins; treat as abort, no strobe.
  - sclk edges while cs_n is high: ignored.
- Reset mid-frame: immediate return to reset values. The frame in progress is lost, and no strobe is generated until a fresh cs_n fall.

Decomposition:
- Shared package:
  - SPI_RW_BIT=7
  - SPI_CMD_BITS=8
  - State encoding constants: IDLE, CMD, DATA, DONE
- One natural sub-module: spi_input_sync. It holds the SYNC_STAGES synchronisers and edge detectors for sclk, cs_n and mosi, and outputs sclk_rise, sclk_fall, cs_fall, cs_rise and mosi_s.

Test Plan:
- Write frame: cmd 0x90, data 0x80FF0000 at sclk=clk/8 -> reg_address=0x10, reg_wdata=0x80FF0000, one reg_wvalid pulse, no reg_read.
- Read frame: cmd 0x00, reg_rdata model returns 0x41010203 one clk after the address -> MISO shifts 0x41010203 MSB first; one reg_read pulse after the 32nd data rise.
- Abort: write cmd 0xA1, cs_n raised after 20 data bits -> one frame_abort pulse, no reg_wvalid, reg_wdata unchanged, reg_address=0x21.
- Back-to-back frames: read 0x01 then write 0x02 with 1 sclk period of cs_n high between them -> exactly one reg_read, then one reg_wvalid with the correct address. spi_miso_oe=0 between frames.
- Overclock: 48 sclk cycles within one cs_n low period on a write -> one reg_wvalid only; MISO stays 0 after bit 40.
- Reset: rst asserted at data bit 10 of a write, then a fresh full write frame -> no strobe from the first frame, correct single strobe from the second. Outputs are at reset values while rst is high.
